rv2t_machine_timer: RTL

// - RISC-V machine timer (mtime/mtimecmp); directly upstream of the CSR block.
// - Its timer_triggered output drives the CSR block's timer_triggered input, which sets mtip on a rising edge.
// - Memory-mapped on the 32-bit peripheral bus; the 64-bit counter and comparator are accessed as 32-bit halves.
// - Gives software an atomic 64-bit read through a high-word shadow latched on each low-word read.

---
 rtl/rv2t_machine_timer_pkg.sv | 22 ++
 rtl/rv2t_machine_timer_tick_prescaler.sv | 42 ++++
 rtl/rv2t_machine_timer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rv2t_machine_timer_pkg.sv
// Shared definitions for the RISC-V machine timer: register map indices,
// comparator reset value and CTRL layout.
package rv2t_machine_timer_pkg;

    localparam int unsigned REG_MTIME_LO    = 0;
    localparam int unsigned REG_MTIME_HI    = 1;
    localparam int unsigned REG_MTIMECMP_LO = 2;
    localparam int unsigned REG_MTIMECMP_HI = 3;
    localparam int unsigned REG_CTRL        = 4;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned PRESCALE_W   = 16;

    function automatic logic [31:0] ctrl_word(input logic en);
        logic [31:0] w;
        w              = '0;
        w[CTRL_EN_BIT] = en;
        return w;
    endfunction

endpackage

// File: rtl/rv2t_machine_timer_tick_prescaler.sv
// Divides clk by TICK_DIV while enabled; emits a one-cycle tick on the last count.
// The count freezes while disabled and can be restarted from zero.
module rv2t_tick_prescaler
    import rv2t_machine_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] CNT_LAST = PRESCALE_W'(TICK_DIV - 1);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    assign tick = en & (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (sync_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rv2t_machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp behind a 32-bit register window,
// with a high-word shadow for atomic reads and a registered compare output.
module rv2t_machine_timer
    import rv2t_machine_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_reset,
    input  logic                 mm_reg_enable_in,
    input  logic                 mm_reg_read_req,
    input  logic                 mm_reg_write_req,
    input  logic [ADDR_BITS-1:0] mm_reg_addr_in,
    input  logic [31:0]          mm_reg_data_in,
    output logic                 mm_reg_read_ack,
    output logic [31:0]          mm_reg_data_out,
    output logic                 timer_triggered,
    output logic [63:0]          mtime_out
);

    logic [63:0] mtime_q,  mtime_d;
    logic [63:0] cmp_q,    cmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        en_q,     en_d;
    logic        ack_q,    ack_d;
    logic        trig_q,   trig_d;

    logic        rd;
    logic        wr;
    logic        tick;
    logic        restart;
    logic [31:0] addr_w;
    logic [31:0] rd_val;

    assign addr_w = 32'(mm_reg_addr_in);
    assign rd     = mm_reg_enable_in & mm_reg_read_req;
    // A read takes priority: a simultaneous write is dropped.
    assign wr     = mm_reg_enable_in & mm_reg_write_req & ~mm_reg_read_req;

    assign restart = wr & (addr_w == REG_CTRL) & mm_reg_data_in[CTRL_EN_BIT] & ~en_q;

    rv2t_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_reset (sync_reset),
        .en         (en_q),
        .restart    (restart),
        .tick       (tick)
    );

    always_comb begin
        rd_val = '0;
        case (addr_w)
            REG_MTIME_LO:    rd_val = mtime_q[31:0];
            REG_MTIME_HI:    rd_val = shadow_q;
            REG_MTIMECMP_LO: rd_val = cmp_q[31:0];
            REG_MTIMECMP_HI: rd_val = cmp_q[63:32];
            REG_CTRL:        rd_val = ctrl_word(en_q);
            default:         rd_val = '0;
        endcase
    end

    always_comb begin
        mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
        cmp_d    = cmp_q;
        shadow_d = shadow_q;
        en_d     = en_q;
        rdata_d  = rdata_q;
        ack_d    = rd;
        trig_d   = en_q & (mtime_q >= cmp_q);

        // Writing either mtime half replaces the pending increment.
        if (wr) begin
            case (addr_w)
                REG_MTIME_LO:    mtime_d = {mtime_q[63:32], mm_reg_data_in};
                REG_MTIME_HI:    mtime_d = {mm_reg_data_in, mtime_q[31:0]};
                REG_MTIMECMP_LO: cmp_d   = {cmp_q[63:32], mm_reg_data_in};
                REG_MTIMECMP_HI: cmp_d   = {mm_reg_data_in, cmp_q[31:0]};
                REG_CTRL:        en_d    = mm_reg_data_in[CTRL_EN_BIT];
                default:         ;
            endcase
        end

        if (rd) begin
            rdata_d = rd_val;
            if (addr_w == REG_MTIME_LO) begin
                shadow_d = mtime_q[63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime_q  <= '0;
            cmp_q    <= MTIMECMP_RST;
            shadow_q <= '0;
            rdata_q  <= '0;
            en_q     <= 1'b1;
            ack_q    <= 1'b0;
            trig_q   <= 1'b0;
        end else if (sync_reset) begin
            mtime_q  <= '0;
            cmp_q    <= MTIMECMP_RST;
            shadow_q <= '0;
            rdata_q  <= '0;
            en_q     <= 1'b1;
            ack_q    <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            en_q     <= en_d;
            ack_q    <= ack_d;
            trig_q   <= trig_d;
        end
    end

    assign mm_reg_read_ack = ack_q;
    assign mm_reg_data_out = rdata_q;
    assign timer_triggered = trig_q;
    assign mtime_out       = mtime_q;

endmodule
